// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes an RV32I instruction plus register read data into an ALU
// operation/operand pair, holding it in a main entry plus a skid entry so that in_ready is registered.
module alu_issue_stage #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_rs1_data,
   input  logic [DATA_W-1:0] in_rs2_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_operation,
   output logic [DATA_W-1:0] out_operand1,
   output logic [DATA_W-1:0] out_operand2,
   output logic [4:0]        out_rd,
   output logic              out_reg_write,
   output logic              out_illegal
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLL = 4'b0111;
   localparam logic [3:0] OP_SRL = 4'b1000;
   localparam logic [3:0] OP_SRA = 4'b1001;
   localparam logic [3:0] OP_XOR = 4'b1010;
   localparam logic [3:0] OP_SLT = 4'b1111;

   typedef struct packed {
      logic [3:0]        op;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [4:0]        rd;
      logic              rw;
      logic              ill;
   } issue_t;

   function automatic logic [DATA_W-1:0] sext12(input logic signed [11:0] imm);
      sext12 = DATA_W'(imm);
   endfunction

   function automatic logic [DATA_W-1:0] shamt(input logic [DATA_W-1:0] val);
      logic [DATA_W-1:0] res;
      res = '0;
      res[SHAMT_W-1:0] = val[SHAMT_W-1:0];
      shamt = res;
   endfunction

   function automatic issue_t decode(input logic [31:0] instr,
                                     input logic [DATA_W-1:0] rs1,
                                     input logic [DATA_W-1:0] rs2);
      issue_t     d;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       f7_zero;
      logic       f7_alt;
      opc     = instr[6:0];
      f3      = instr[14:12];
      f7      = instr[31:25];
      f7_zero = (f7 == 7'b0000000);
      f7_alt  = (f7 == 7'b0100000);
      d.op  = OP_ADD;
      d.op1 = rs1;
      d.op2 = rs2;
      d.rd  = instr[11:7];
      d.rw  = 1'b0;
      d.ill = 1'b0;
      case (opc)
         7'b0110011: begin
            d.rw = 1'b1;
            case (f3)
               3'b000: begin d.op = f7_alt ? OP_SUB : OP_ADD; d.ill = !(f7_zero || f7_alt); end
               3'b001: begin d.op = OP_SLL; d.op2 = shamt(rs2); d.ill = !f7_zero; end
               3'b010: begin d.op = OP_SLT; d.ill = !f7_zero; end
               3'b100: begin d.op = OP_XOR; d.ill = !f7_zero; end
               3'b101: begin
                  d.op  = f7_alt ? OP_SRA : OP_SRL;
                  d.op2 = shamt(rs2);
                  d.ill = !(f7_zero || f7_alt);
               end
               3'b110: begin d.op = OP_OR;  d.ill = !f7_zero; end
               3'b111: begin d.op = OP_AND; d.ill = !f7_zero; end
               default: d.ill = 1'b1;
            endcase
         end
         7'b0010011: begin
            d.rw  = 1'b1;
            d.op2 = sext12(instr[31:20]);
            case (f3)
               3'b000: d.op = OP_ADD;
               3'b010: d.op = OP_SLT;
               3'b100: d.op = OP_XOR;
               3'b110: d.op = OP_OR;
               3'b111: d.op = OP_AND;
               3'b001: begin d.op = OP_SLL; d.op2 = shamt(DATA_W'(instr[24:20])); d.ill = !f7_zero; end
               3'b101: begin
                  d.op  = f7_alt ? OP_SRA : OP_SRL;
                  d.op2 = shamt(DATA_W'(instr[24:20]));
                  d.ill = !(f7_zero || f7_alt);
               end
               default: d.ill = 1'b1;
            endcase
         end
         7'b0000011: begin d.rw = 1'b1; d.op2 = sext12(instr[31:20]); end
         7'b0100011: d.op2 = sext12({instr[31:25], instr[11:7]});
         7'b1100011: begin d.op = OP_SUB; d.ill = (f3[2:1] != 2'b00); end
         default: d.ill = 1'b1;
      endcase
      if (d.ill) begin
         d.op  = OP_ADD;
         d.op1 = '0;
         d.op2 = '0;
         d.rw  = 1'b0;
      end
      if (!d.rw) d.rd = 5'd0;
      decode = d;
   endfunction

   issue_t dec_p0;
   issue_t main_p1;
   issue_t skid_p1;
   logic   vld_p1;
   logic   skid_vld_p1;
   logic   in_rdy_p1;
   logic   fire_in;
   logic   fire_out;

   // p0: combinational decode of the presented instruction
   always_comb begin
      dec_p0 = decode(in_instr, in_rs1_data, in_rs2_data);
   end

   assign fire_in  = in_valid && in_rdy_p1;
   assign fire_out = vld_p1 && out_ready;

   // p1: main/skid buffer; in_rdy_p1 always mirrors an empty skid entry
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         in_rdy_p1   <= 1'b1;
         main_p1     <= '0;
         skid_p1     <= '0;
      end else if (flush) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         in_rdy_p1   <= 1'b1;
      end else if (skid_vld_p1 && fire_out) begin
         main_p1     <= skid_p1;
         skid_vld_p1 <= 1'b0;
         in_rdy_p1   <= 1'b1;
      end else if (fire_in && (!vld_p1 || fire_out)) begin
         main_p1 <= dec_p0;
         vld_p1  <= 1'b1;
      end else if (fire_in) begin
         skid_p1     <= dec_p0;
         skid_vld_p1 <= 1'b1;
         in_rdy_p1   <= 1'b0;
      end else if (fire_out) begin
         vld_p1 <= 1'b0;
      end
   end

   assign in_ready      = in_rdy_p1;
   assign out_valid     = vld_p1;
   assign out_operation = main_p1.op;
   assign out_operand1  = main_p1.op1;
   assign out_operand2  = main_p1.op2;
   assign out_rd        = main_p1.rd;
   assign out_reg_write = main_p1.rw;
   assign out_illegal   = main_p1.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure, flush, reset, illegal ops.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_operation;
   logic [31:0] out_operand1;
   logic [31:0] out_operand2;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_illegal;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h40208233;
   localparam logic [31:0] I_SLL  = 32'h002092B3;
   localparam logic [31:0] I_SRAI = 32'h4030D093;
   localparam logic [31:0] I_ADDI = 32'hFFF08313;
   localparam logic [31:0] I_SW   = 32'hFE20AE23;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_XOR  = 32'h0020C3B3;
   localparam logic [31:0] I_SLTU = 32'h0020B1B3;
   localparam logic [31:0] I_JAL  = 32'h0000006F;
   localparam logic [31:0] I_BADF = 32'h022081B3;

   alu_issue_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_operation(out_operation),
      .out_operand1(out_operand1), .out_operand2(out_operand2), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
      in_valid    = v;
      in_instr    = instr;
      in_rs1_data = a;
      in_rs2_data = b;
   endtask

   task automatic chk_op(input string tag, input logic [3:0] op, input logic [31:0] o1,
                         input logic [31:0] o2, input logic [4:0] rd, input logic rw, input logic ill);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".op"},    32'(out_operation), 32'(op));
      chk({tag, ".op1"},   out_operand1, o1);
      chk({tag, ".op2"},   out_operand2, o2);
      chk({tag, ".rd"},    32'(out_rd), 32'(rd));
      chk({tag, ".rw"},    32'(out_reg_write), 32'(rw));
      chk({tag, ".ill"},   32'(out_illegal), 32'(ill));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".op"},    32'(out_operation), 32'd0);
      chk({tag, ".op1"},   out_operand1, 32'd0);
      chk({tag, ".op2"},   out_operand2, 32'd0);
      chk({tag, ".rd"},    32'(out_rd), 32'd0);
      chk({tag, ".rw"},    32'(out_reg_write), 32'd0);
      chk({tag, ".ill"},   32'(out_illegal), 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      step(); step();
      chk_reset("reset");
      rst = 1'b0;

      // Decode stream with out_ready held high
      out_ready = 1'b1;
      drive(1'b1, I_ADD, 32'd5, 32'd7);
      #1 chk("pre_accept.valid", 32'(out_valid), 32'd0);
      step(); chk_op("add", 4'b0010, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
      drive(1'b1, I_SUB, 32'd5, 32'd7);
      step(); chk_op("sub", 4'b0110, 32'd5, 32'd7, 5'd4, 1'b1, 1'b0);
      drive(1'b1, I_SLL, 32'd9, 32'h25);
      step(); chk_op("sll", 4'b0111, 32'd9, 32'h5, 5'd5, 1'b1, 1'b0);
      drive(1'b1, I_SRAI, 32'hF0, 32'h1234);
      step(); chk_op("srai", 4'b1001, 32'hF0, 32'd3, 5'd1, 1'b1, 1'b0);
      drive(1'b1, I_ADDI, 32'd1, 32'd2);
      step(); chk_op("addi", 4'b0010, 32'd1, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0);
      drive(1'b1, I_SW, 32'h100, 32'd2);
      step(); chk_op("sw", 4'b0010, 32'h100, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0);
      drive(1'b1, I_BEQ, 32'd5, 32'd7);
      step(); chk_op("beq", 4'b0110, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0);

      // Illegal encodings still handshake out exactly once each
      drive(1'b1, I_SLTU, 32'd5, 32'd7);
      step(); chk_op("sltu", 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      drive(1'b1, I_JAL, 32'd5, 32'd7);
      step(); chk_op("jal", 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      drive(1'b1, I_BADF, 32'd5, 32'd7);
      step(); chk_op("badf7", 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      step(); chk("drain.valid", 32'(out_valid), 32'd0);

      // Backpressure: three inputs, only two fit
      out_ready = 1'b0;
      drive(1'b1, I_ADD, 32'd1, 32'd2);
      step(); chk("bp1.ready", 32'(in_ready), 32'd1);
      drive(1'b1, I_SUB, 32'd3, 32'd4);
      step(); chk("bp2.ready", 32'(in_ready), 32'd0);
      chk_op("bp2.hold", 4'b0010, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0);
      drive(1'b1, I_XOR, 32'd5, 32'd6);
      step(); chk("bp3.ready", 32'(in_ready), 32'd0);
      chk_op("bp3.hold", 4'b0010, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0);
      out_ready = 1'b1;
      step(); chk_op("bp.skid", 4'b0110, 32'd3, 32'd4, 5'd4, 1'b1, 1'b0);
      chk("bp.skid.ready", 32'(in_ready), 32'd1);
      step(); chk_op("bp.third", 4'b1010, 32'd5, 32'd6, 5'd7, 1'b1, 1'b0);
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      step(); chk("bp.empty", 32'(out_valid), 32'd0);

      // Flush with both entries full and an input presented
      out_ready = 1'b0;
      drive(1'b1, I_ADD, 32'd1, 32'd2);
      step();
      drive(1'b1, I_SUB, 32'd3, 32'd4);
      step(); chk("fl.full.ready", 32'(in_ready), 32'd0);
      drive(1'b1, I_XOR, 32'd5, 32'd6);
      flush = 1'b1;
      step(); chk("fl.valid", 32'(out_valid), 32'd0);
      chk("fl.ready", 32'(in_ready), 32'd1);
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      out_ready = 1'b1;
      step(); chk("fl.dropped", 32'(out_valid), 32'd0);

      // Reset mid-stream
      out_ready = 1'b0;
      drive(1'b1, I_ADD, 32'd1, 32'd2);
      step(); chk("rs.pre.valid", 32'(out_valid), 32'd1);
      drive(1'b1, I_SUB, 32'd3, 32'd4);
      rst = 1'b1;
      step(); chk_reset("rs.mid");
      rst = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      step(); chk("rs.post.valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
